strip_result_reader: RTL

STRIP_RESULT_READER -- requirements
Module: strip_result_reader

---
 rtl/strip_result_reader_pkg.sv | 18 +
 rtl/result_fifo.sv | 59 +++++
 rtl/strip_result_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/strip_result_reader_pkg.sv
// Shared widths, FSM encoding and default geometry for the strip result reader.
package strip_result_reader_pkg;

    localparam int RESULT_W                = 23;
    localparam int ADDR_W                  = 13;
    localparam int STRIP_W                 = 3;
    // 222 horizontal x 28 vertical slides per strip
    localparam int DEFAULT_WORDS_PER_STRIP = 6216;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DONE = 3'd1,
        READ      = 3'd2,
        DRAIN     = 3'd3,
        FIN       = 3'd4
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Small shift-register FIFO; entry 0 is always the head, so the output is a
// plain register and nothing downstream-combinational reaches it.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             head,
    output logic                         not_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop;
    logic             full;
    int               wr_idx;

    assign pop       = rd_en && not_empty;
    assign not_empty = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head      = mem[0];

    // New word lands just behind the surviving entries (after any pop this cycle)
    always_comb wr_idx = int'(count) - (pop ? 1 : 0);

    // Storage: shift toward the head on pop, write at the tail slot on push
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (i == wr_idx)) begin
                mem[i] <= wr_data;
            end else if (pop && (i < DEPTH-1)) begin
                mem[i] <= mem[(i < DEPTH-1) ? i+1 : i];
            end
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= CNT_W'(int'(count) + (wr_en ? 1 : 0) - (pop ? 1 : 0));
        end
    end

    // A push into a full FIFO means the upstream credit logic is broken
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(wr_en && full && !pop));
        end
    end

endmodule

// File: rtl/strip_result_reader.sv
// Reads every conv strip unit's result memory in turn and streams the words
// out over a valid/ready port, tagged with strip index and end-of-frame.
module strip_result_reader
    import strip_result_reader_pkg::*;
#(
    parameter int NUM_STRIPS      = 8,
    parameter int WORDS_PER_STRIP = DEFAULT_WORDS_PER_STRIP,
    parameter int RD_LAT          = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_STRIPS-1:0]          strip_done,
    input  logic [NUM_STRIPS*RESULT_W-1:0] strip_data,
    output logic [ADDR_W-1:0]              strip_addr,
    output logic [RESULT_W-1:0]            m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_last,
    output logic [STRIP_W-1:0]             m_strip,
    output logic                           busy,
    output logic                           frame_done
);

    localparam int ENTRY_W = RESULT_W + STRIP_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH+1);
    localparam int INF_W   = $clog2(RD_LAT+1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(WORDS_PER_STRIP-1);
    localparam logic [STRIP_W-1:0] LAST_STRIP = STRIP_W'(NUM_STRIPS-1);

    state_t                      state;
    logic [STRIP_W-1:0]          k;
    logic [ADDR_W-1:0]           addr_cnt;
    logic [RD_LAT-1:0]           vld_p;
    logic [RD_LAT-1:0]           last_p;
    logic [INF_W-1:0]            inflight;
    logic [CNT_W-1:0]            fifo_count;
    int                          occupancy;
    logic                        issue;
    logic                        issue_last;
    logic                        capture;
    logic                        pop;
    logic                        strip_empty;
    logic                        done_k;
    logic signed [RESULT_W-1:0]  cap_word;
    logic [ENTRY_W-1:0]          wr_entry;
    logic [ENTRY_W-1:0]          head;

    assign pop     = m_valid && m_ready;
    assign capture = vld_p[RD_LAT-1];

    // Select the active unit's done flag and read data
    always_comb begin
        done_k   = 1'b0;
        cap_word = '0;
        for (int i = 0; i < NUM_STRIPS; i++) begin
            if (int'(k) == i) begin
                done_k   = strip_done[i];
                cap_word = strip_data[i*RESULT_W +: RESULT_W];
            end
        end
    end

    // Words already requested from the memories but not yet captured
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + INF_W'(vld_p[i]);
        end
    end

    // Credit check counts the slot freed by a transfer this cycle, which is
    // what lets a FIFO of RD_LAT+1 sustain one word per cycle
    always_comb begin
        occupancy  = int'(fifo_count) + int'(inflight) - (pop ? 1 : 0);
        issue      = (state == READ) && (occupancy < FIFO_DEPTH);
        issue_last = issue && (addr_cnt == LAST_ADDR) && (k == LAST_STRIP);
        strip_empty = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));
    end

    // Read-latency valid pipe: an issued address becomes a capture RD_LAT cycles later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p  <= (vld_p << 1)  | RD_LAT'(issue);
            last_p <= (last_p << 1) | RD_LAT'(issue_last);
        end
    end

    // Frame sequencing FSM: wait for each strip, read it out, drain, next strip
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            k          <= '0;
            addr_cnt   <= '0;
            strip_addr <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_DONE;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (done_k) begin
                        state    <= READ;
                        addr_cnt <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        strip_addr <= addr_cnt;
                        if (addr_cnt == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (strip_empty) begin
                        if (k == LAST_STRIP) begin
                            state      <= FIN;
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state <= WAIT_DONE;
                            k     <= k + 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign wr_entry = {cap_word, k, last_p[RD_LAT-1]};

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (capture),
        .wr_data   (wr_entry),
        .rd_en     (m_ready),
        .head      (head),
        .not_empty (m_valid),
        .count     (fifo_count)
    );

    // Tags are forced low when nothing is presented so reset leaves them cleared
    assign m_data  = head[ENTRY_W-1 -: RESULT_W];
    assign m_strip = m_valid ? head[STRIP_W:1] : '0;
    assign m_last  = m_valid && head[0];

endmodule
